br_row_reader: RTL

Row fetch engine for the binarization pipeline. It answers the per-row read handshake of the row sequencer: on each single-cycle `Rd_Start_i` pulse it reads one image row from external memory over an Avalon-MM read master and writes the row into the local line buffer. When the last word of the row has been stored, it returns a single-cycle `Read_Done_o` pulse. It keeps its own row index, so successive starts walk down the frame.

---
 rtl/br_row_reader.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/br_row_reader.sv
// br_row_reader: fetches one image row per start pulse over an Avalon-MM
// read master and writes each returned word into the local line buffer.
// A private row index walks down the frame; frame_start_i rewinds it.
// Optional build macro: BR_ROW_READER_OVERRUN_EN adds a sticky overrun_o
// flag that records start pulses arriving while a row is still in flight.
module br_row_reader #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [15:0]       stride_i,
    input  logic [9:0]        width_i,
    input  logic              Rd_Start_i,
    output logic              Read_Done_o,
    output logic              busy_o,
    output logic [8:0]        row_idx_o,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              lb_we_o,
    output logic [9:0]        lb_addr_o,
    output logic [DATA_W-1:0] lb_data_o
`ifdef BR_ROW_READER_OVERRUN_EN
    ,
    output logic              overrun_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);
    localparam logic [9:0]        MAX_OUT_W  = 10'(MAX_OUT);

    // Registered state
    state_t              state_r;
    logic [9:0]          issued_r;
    logic [9:0]          received_r;
    logic [9:0]          width_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                read_r;
    logic                busy_r;
    logic                done_r;
    logic [8:0]          row_idx_r;
    logic                lb_we_r;
    logic [9:0]          lb_addr_r;
    logic [DATA_W-1:0]   lb_data_r;

    // Next-state values
    state_t              state_nx_s;
    logic [9:0]          issued_nx_s;
    logic [9:0]          received_nx_s;
    logic [9:0]          width_nx_s;
    logic [ADDR_W-1:0]   addr_nx_s;
    logic                read_nx_s;
    logic                busy_nx_s;
    logic                done_nx_s;
    logic [8:0]          row_idx_nx_s;
    logic                lb_we_nx_s;
    logic [9:0]          lb_addr_nx_s;
    logic [DATA_W-1:0]   lb_data_nx_s;

    // Decoded events
    logic                idle_s;
    logic                start_s;
    logic                accept_s;
    logic                rdv_s;
    logic [8:0]          row_eff_s;
    logic [ADDR_W-1:0]   row_base_s;
    logic [9:0]          outstanding_nx_s;

    // Event decode. The cycle in which Read_Done_o is high still counts as
    // busy, so a start pulse coinciding with the done pulse is not taken.
    always_comb begin
        idle_s    = (state_r == IDLE) && !busy_r;
        start_s   = Rd_Start_i && idle_s;
        accept_s  = read_r && !avm_waitrequest;
        rdv_s     = avm_readdatavalid && (state_r != IDLE);
        if (frame_start_i && idle_s) begin
            row_eff_s = 9'd0;
        end else begin
            row_eff_s = row_idx_r;
        end
        row_base_s = base_addr_i + (ADDR_W'(row_eff_s) * ADDR_W'(stride_i));
    end

    // Row FSM next state plus issue/receive counter and address updates.
    // ISSUE->DRAIN and DRAIN->DONE look ahead at the counter values after
    // this edge so that the done pulse follows the last response by two.
    always_comb begin
        state_nx_s    = state_r;
        width_nx_s    = width_r;
        if (accept_s) begin
            issued_nx_s = issued_r + 10'd1;
            addr_nx_s   = addr_r + WORD_BYTES;
        end else begin
            issued_nx_s = issued_r;
            addr_nx_s   = addr_r;
        end
        if (rdv_s) begin
            received_nx_s = received_r + 10'd1;
        end else begin
            received_nx_s = received_r;
        end
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    issued_nx_s   = 10'd0;
                    received_nx_s = 10'd0;
                    width_nx_s    = width_i;
                    addr_nx_s     = row_base_s;
                    if (width_i == 10'd0) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = ISSUE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                if (issued_nx_s == width_r) begin
                    state_nx_s = DRAIN;
                end else begin
                    state_nx_s = ISSUE;
                end
            end
            DRAIN: begin
                if (received_nx_s == width_r) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Read request, status pulses, row index and line-buffer write values.
    always_comb begin
        outstanding_nx_s = issued_nx_s - received_nx_s;
        if ((state_nx_s == ISSUE) && (issued_nx_s != width_nx_s) &&
            (outstanding_nx_s < MAX_OUT_W)) begin
            read_nx_s = 1'b1;
        end else begin
            read_nx_s = 1'b0;
        end
        done_nx_s = (state_r == DONE);
        busy_nx_s = (state_nx_s != IDLE) || (state_r == DONE);
        if (state_r == DONE) begin
            row_idx_nx_s = row_idx_r + 9'd1;
        end else if (frame_start_i && idle_s) begin
            row_idx_nx_s = 9'd0;
        end else begin
            row_idx_nx_s = row_idx_r;
        end
        lb_we_nx_s = rdv_s;
        if (rdv_s) begin
            lb_addr_nx_s = received_r;
            lb_data_nx_s = avm_readdata;
        end else begin
            lb_addr_nx_s = lb_addr_r;
            lb_data_nx_s = lb_data_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            issued_r   <= 10'd0;
            received_r <= 10'd0;
            width_r    <= 10'd0;
            addr_r     <= '0;
            read_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            row_idx_r  <= 9'd0;
            lb_we_r    <= 1'b0;
            lb_addr_r  <= 10'd0;
            lb_data_r  <= '0;
        end else begin
            state_r    <= state_nx_s;
            issued_r   <= issued_nx_s;
            received_r <= received_nx_s;
            width_r    <= width_nx_s;
            addr_r     <= addr_nx_s;
            read_r     <= read_nx_s;
            busy_r     <= busy_nx_s;
            done_r     <= done_nx_s;
            row_idx_r  <= row_idx_nx_s;
            lb_we_r    <= lb_we_nx_s;
            lb_addr_r  <= lb_addr_nx_s;
            lb_data_r  <= lb_data_nx_s;
        end
    end

`ifdef BR_ROW_READER_OVERRUN_EN
    logic overrun_r;

    // Sticky overrun flag: a new start while a row is in flight sets it,
    // and only reset or a frame start clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (Rd_Start_i && !idle_s) begin
            overrun_r <= 1'b1;
        end else if (frame_start_i) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign overrun_o = overrun_r;
`endif

    assign Read_Done_o = done_r;
    assign busy_o      = busy_r;
    assign row_idx_o   = row_idx_r;
    assign avm_address = addr_r;
    assign avm_read    = read_r;
    assign lb_we_o     = lb_we_r;
    assign lb_addr_o   = lb_addr_r;
    assign lb_data_o   = lb_data_r;

endmodule
